compare_tracker: RTL and testbench



---
 rtl/compare_tracker.sv | 95 +++++++++
 tb/tb_compare_tracker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/compare_tracker.sv
// compare_tracker: qualifies comparator EQ/GTR/LR flags after STABLE_CNT identical samples.
// Optional sticky error flag: define COMPARE_TRACKER_STICKY_ERR_EN.
module compare_tracker #(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             EQ,
  input  logic             GTR,
  input  logic             LR,
  output logic             stable_eq,
  output logic             stable_gtr,
  output logic             stable_lr,
  output logic             chg_pulse,
  output logic             err,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_gtr,
  output logic [CNT_W-1:0] cnt_lr
);
  typedef enum logic [1:0] {IDLE, QUAL, STABLE} state_t;
  state_t state_q, state_d;
  logic [2:0] code, cand_q, cand_d, stab_q, stab_d;
  logic [7:0] qcnt_q, qcnt_d;
  logic chg_q, chg_d, err_q, err_d, legal, hit, new_res;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  assign code    = {GTR, EQ, LR};
  assign legal   = $onehot(code);
  assign hit     = en && state_q == QUAL && code == cand_q && qcnt_q == 8'(STABLE_CNT - 1);
  assign new_res = hit && cand_q != stab_q;
  // next-state: candidate tracking, qualification, pulses and saturating counters
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    qcnt_d  = qcnt_q;
    stab_d  = stab_q;
    chg_d   = 1'b0;
    cnt_d   = cnt_q;
`ifdef COMPARE_TRACKER_STICKY_ERR_EN
    err_d   = err_q;
`else
    err_d   = 1'b0;
`endif
    if (en) begin
      if (!legal) begin
        state_d = IDLE;
        qcnt_d  = '0;
      end else if (state_q == IDLE || code != cand_q) begin
        state_d = QUAL;
        cand_d  = code;
        qcnt_d  = 8'd1;
      end else if (state_q == QUAL) begin
        state_d = hit ? STABLE : QUAL;
        stab_d  = hit ? cand_q : stab_q;
        qcnt_d  = hit ? qcnt_q : qcnt_q + 8'd1;
        chg_d   = new_res;
      end
`ifdef COMPARE_TRACKER_STICKY_ERR_EN
      err_d = !legal || (err_q && !clr);
`else
      err_d = !legal;
`endif
      for (int i = 0; i < 3; i++)
        cnt_d[i] = clr ? '0 : (new_res && cand_q[i] && cnt_q[i] != '1) ? cnt_q[i] + 1'b1 : cnt_q[i];
    end
  end
  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cand_q  <= '0;
      qcnt_q  <= '0;
      stab_q  <= '0;
      chg_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      qcnt_q  <= qcnt_d;
      stab_q  <= stab_d;
      chg_q   <= chg_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign {stable_gtr, stable_eq, stable_lr} = stab_q;
  assign chg_pulse = chg_q;
  assign err       = err_q;
  assign cnt_lr    = cnt_q[0];
  assign cnt_eq    = cnt_q[1];
  assign cnt_gtr   = cnt_q[2];
endmodule

// File: tb/tb_compare_tracker.sv
// tb_compare_tracker: randomized and directed checks of compare_tracker against a run-length model.
module tb_compare_tracker;
  localparam int N = 4;
  localparam int W = 2;
  localparam int SAT = (1 << W) - 1;
  logic clk = 1'b0, rst, en, clr, EQ, GTR, LR;
  logic stable_eq, stable_gtr, stable_lr, chg_pulse, err;
  logic [W-1:0] cnt_eq, cnt_gtr, cnt_lr;
  int total = 0, bad = 0;
  logic [2:0] m_run, m_last;
  int m_len;
  int m_cnt [3];
  logic m_chg, m_err;
  logic [10:0] obs;

  compare_tracker #(.STABLE_CNT(N), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .EQ(EQ), .GTR(GTR), .LR(LR),
    .stable_eq(stable_eq), .stable_gtr(stable_gtr), .stable_lr(stable_lr),
    .chg_pulse(chg_pulse), .err(err), .cnt_eq(cnt_eq), .cnt_gtr(cnt_gtr), .cnt_lr(cnt_lr)
  );

  always #5 clk = ~clk;
  assign obs = {stable_gtr, stable_eq, stable_lr, chg_pulse, err, cnt_eq, cnt_gtr, cnt_lr};

  function automatic logic [10:0] expv();
    return {m_last, m_chg, m_err, W'(m_cnt[1]), W'(m_cnt[2]), W'(m_cnt[0])};
  endfunction

  task automatic model_reset();
    m_run = '0; m_last = '0; m_len = 0; m_chg = 1'b0; m_err = 1'b0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
  endtask

  // A result qualifies when the current run of identical legal samples reaches length N.
  task automatic drive(input logic e, input logic c, input logic [2:0] code);
    logic legal;
    en = e; clr = c; {GTR, EQ, LR} = code;
    @(posedge clk);
    m_chg = 1'b0;
    if (!e) begin
`ifndef COMPARE_TRACKER_STICKY_ERR_EN
      m_err = 1'b0;
`endif
    end else begin
      legal = ($countones(code) == 1);
      if (!legal) m_len = 0;
      else begin
        if (m_len > 0 && code == m_run) m_len++;
        else begin m_run = code; m_len = 1; end
        if (m_len == N && code != m_last) begin
          m_chg = 1'b1;
          m_last = code;
          for (int i = 0; i < 3; i++) if (code[i] && m_cnt[i] < SAT) m_cnt[i]++;
        end
      end
      if (c) for (int i = 0; i < 3; i++) m_cnt[i] = 0;
`ifdef COMPARE_TRACKER_STICKY_ERR_EN
      m_err = !legal || (m_err && !c);
`else
      m_err = !legal;
`endif
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; {GTR, EQ, LR} = 3'b000;
    model_reset();
    #12;
    total++;
    if (obs !== 11'd0) begin bad++; $display("FAIL reset: got %h want 000", obs); end
    rst = 1'b0;
  endtask

  task automatic test_qualify();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 3'b100);
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL qualify step %0d: got %h want %h", i, obs, expv()); end
      if (i == 3) begin
        total++;
        if ({stable_gtr, chg_pulse, cnt_gtr} !== {1'b1, 1'b1, W'(1)})
          begin bad++; $display("FAIL qualify_4th: got %b%b%0d want 111", stable_gtr, chg_pulse, cnt_gtr); end
      end
    end
  endtask

  task automatic test_glitch();
    logic [2:0] seq [5] = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b100};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, seq[i]);
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL glitch step %0d: got %h want %h", i, obs, expv()); end
    end
    total++;
    if ({stable_gtr, chg_pulse, cnt_lr} !== {1'b1, 1'b0, W'(0)})
      begin bad++; $display("FAIL glitch_hold: got %b%b%0d want 100", stable_gtr, chg_pulse, cnt_lr); end
  endtask

  task automatic test_change();
    logic [2:0] seq [3] = '{3'b001, 3'b010, 3'b001};
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) begin
        drive(1'b1, 1'b0, seq[k]);
        total++;
        if (obs !== expv()) begin bad++; $display("FAIL change %0d.%0d: got %h want %h", k, i, obs, expv()); end
      end
    total++;
    if ({stable_lr, cnt_lr, cnt_eq} !== {1'b1, W'(2), W'(1)})
      begin bad++; $display("FAIL change_counts: got lr=%b cnt_lr=%0d cnt_eq=%0d want 1 2 1", stable_lr, cnt_lr, cnt_eq); end
  endtask

  task automatic test_illegal();
    drive(1'b1, 1'b0, 3'b010);
    drive(1'b1, 1'b0, 3'b010);
    drive(1'b1, 1'b0, 3'b110);
    total++;
    if ({err, obs} !== {1'b1, expv()}) begin bad++; $display("FAIL illegal_err: got %b %h want 1 %h", err, obs, expv()); end
    for (int i = 0; i < N; i++) begin
      drive(1'b1, 1'b0, 3'b010);
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL illegal_restart %0d: got %h want %h", i, obs, expv()); end
      total++;
      if (stable_eq !== (i == N - 1)) begin bad++; $display("FAIL restart_eq %0d: got %b want %b", i, stable_eq, i == N - 1); end
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 10; k++)
      for (int i = 0; i < N; i++) begin
        drive(1'b1, 1'b0, k[0] ? 3'b010 : 3'b100);
        total++;
        if (obs !== expv()) begin bad++; $display("FAIL saturate %0d.%0d: got %h want %h", k, i, obs, expv()); end
      end
    total++;
    if ({cnt_eq, cnt_gtr} !== {W'(SAT), W'(SAT)}) begin bad++; $display("FAIL sat_value: got %0d %0d want %0d", cnt_eq, cnt_gtr, SAT); end
    for (int i = 0; i < N; i++) drive(1'b1, i == N - 1, 3'b001);
    total++;
    if ({chg_pulse, stable_lr, cnt_lr, cnt_eq} !== {1'b1, 1'b1, W'(0), W'(0)})
      begin bad++; $display("FAIL clr_wins: got chg=%b lr=%b cnt_lr=%0d cnt_eq=%0d want 1 1 0 0", chg_pulse, stable_lr, cnt_lr, cnt_eq); end
    total++;
    if (obs !== expv()) begin bad++; $display("FAIL clr_model: got %h want %h", obs, expv()); end
  endtask

  task automatic test_enable();
    logic [10:0] held;
    drive(1'b1, 1'b0, 3'b100);
    drive(1'b1, 1'b0, 3'b100);
    held = obs;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 3'($urandom));
      total++;
      if (obs !== expv() || obs[10:5] !== held[10:5]) begin bad++; $display("FAIL enable_freeze %0d: got %h want %h", i, obs, expv()); end
    end
    drive(1'b1, 1'b0, 3'b100);
    total++;
    if (stable_gtr !== 1'b0) begin bad++; $display("FAIL enable_early: got %b want 0", stable_gtr); end
    drive(1'b1, 1'b0, 3'b100);
    total++;
    if ({stable_gtr, chg_pulse, obs} !== {2'b11, expv()}) begin bad++; $display("FAIL enable_resume: got %h want %h", obs, expv()); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 3'b010);
    drive(1'b1, 1'b0, 3'b010);
    #2 rst = 1'b1;
    #1;
    model_reset();
    total++;
    if (obs !== 11'd0) begin bad++; $display("FAIL async_reset: got %h want 000", obs); end
    #2 rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      drive(1'b1, 1'b0, 3'b010);
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL post_reset %0d: got %h want %h", i, obs, expv()); end
    end
  endtask

  task automatic test_random();
    logic [2:0] code = 3'b001;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) code = 3'($urandom);
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0, code);
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL random %0d: got %h want %h", i, obs, expv()); end
    end
  endtask

  initial begin
    test_reset();
    test_qualify();
    test_glitch();
    test_change();
    test_illegal();
    test_saturate();
    test_enable();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
